sqrt_scheduler: RTL and testbench

- Shares one iterative square-root engine between N_REQ requesters (sensor/measurement channels) with round-robin arbitration.
- Each request carries an 8-bit unsigned integer. The response is floor(sqrt(in) * 16), an unsigned Q4.4 value, tagged with the requester index.
- Sits between the per-channel measurement logic and the downstream consumer. Replaces per-channel combinational square-root instances with one shared multi-cycle engine, one result bit per clock.

---
 rtl/sqrt_pkg.sv | 18 +
 rtl/sqrt_iter_core.sv | 55 +++++
 rtl/sqrt_scheduler.sv | 132 +++++++++++++
 tb/tb_sqrt_scheduler.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared constants and state encoding for the shared square-root scheduler.
package sqrt_pkg;

  localparam int IN_W   = 8;
  localparam int FRAC_W = 4;
  localparam int RES_W  = IN_W / 2 + FRAC_W;
  localparam int RAD_W  = 2 * RES_W;
  localparam int RSP_W  = 16;
  localparam int CNT_W  = $clog2(RES_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sqrt_iter_core.sv
// Bit-serial square-root datapath: radicand, partial root y and bit counter.
// The round-half-up step is only exercised when the scheduler is built with SQRT_ROUND_EN.
module sqrt_iter_core
  import sqrt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_step,
  input  logic             i_round,
  input  logic [IN_W-1:0]  i_operand,
  output logic [RES_W-1:0] o_root,
  output logic             o_last
);

  logic [RAD_W-1:0] r_rad;
  logic [RES_W-1:0] r_y;
  logic [CNT_W-1:0] r_cnt;

  logic [RES_W-1:0] w_trial;
  logic [RAD_W-1:0] w_trial_sq;
  logic [RAD_W-1:0] w_rem;

  // Full-width products: the compare must never see a truncated square.
  assign w_trial    = r_y | (RES_W'(1) << r_cnt);
  assign w_trial_sq = RAD_W'(w_trial) * RAD_W'(w_trial);
  assign w_rem      = r_rad - RAD_W'(r_y) * RAD_W'(r_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rad <= '0;
      r_y   <= '0;
      r_cnt <= '0;
    end else if (i_start) begin
      r_rad <= RAD_W'(i_operand) << (2 * FRAC_W);
      r_y   <= '0;
      r_cnt <= CNT_W'(RES_W - 1);
    end else if (i_step) begin
      if (w_trial_sq <= r_rad) begin
        r_y <= w_trial;
      end
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end else if (i_round) begin
      if ((w_rem > RAD_W'(r_y)) && (r_y != '1)) begin
        r_y <= r_y + 1'b1;
      end
    end
  end

  assign o_root = r_y;
  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/sqrt_scheduler.sv
// Round-robin arbiter + FSM sharing one iterative Q4.4 square-root engine.
// Define SQRT_ROUND_EN to add a one-cycle round-half-up stage after the iteration.
module sqrt_scheduler
  import sqrt_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*IN_W-1:0] req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [RSP_W-1:0]      rsp_data,
  input  logic                  rsp_ready,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_CALC  = CALC;
  localparam logic [1:0] S_DONE  = DONE;
`ifdef SQRT_ROUND_EN
  localparam logic [1:0] S_ROUND = ROUND;
`endif

  logic [1:0]       r_state;
  logic [ID_W-1:0]  r_rr_ptr;
  logic [ID_W-1:0]  r_tag;

  logic [IN_W-1:0]  w_op [N_REQ];
  logic [ID_W-1:0]  w_grant;
  logic [ID_W-1:0]  w_next_ptr;
  logic             w_any;
  logic             w_accept;
  logic             w_last;
  logic             w_round;
  logic [RES_W-1:0] w_root;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign w_op[gi]      = req_data[gi*IN_W +: IN_W];
      assign req_ready[gi] = w_accept && (w_grant == ID_W'(gi));
    end
  endgenerate

  // Search upward from the round-robin pointer with wrap; first hit wins.
  always_comb begin
    logic [ID_W:0] v_idx;
    logic [ID_W:0] v_nxt;
    v_idx   = '0;
    v_nxt   = '0;
    w_any   = 1'b0;
    w_grant = '0;
    for (int j = 0; j < N_REQ; j++) begin
      v_idx = {1'b0, r_rr_ptr} + (ID_W+1)'(j);
      if (v_idx >= (ID_W+1)'(N_REQ)) begin
        v_idx = v_idx - (ID_W+1)'(N_REQ);
      end
      if (!w_any && req_valid[v_idx[ID_W-1:0]]) begin
        w_any   = 1'b1;
        w_grant = v_idx[ID_W-1:0];
      end
    end
    v_nxt      = {1'b0, w_grant} + 1'b1;
    w_next_ptr = (v_nxt >= (ID_W+1)'(N_REQ)) ? '0 : v_nxt[ID_W-1:0];
  end

  assign w_accept = (r_state == S_IDLE) && w_any && !rst;

`ifdef SQRT_ROUND_EN
  assign w_round = (r_state == S_ROUND);
`else
  assign w_round = 1'b0;
`endif

  sqrt_iter_core u_core (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_accept),
    .i_step    (r_state == S_CALC),
    .i_round   (w_round),
    .i_operand (w_op[w_grant]),
    .o_root    (w_root),
    .o_last    (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_tag    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_tag    <= w_grant;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          if (w_last) begin
`ifdef SQRT_ROUND_EN
            r_state <= S_ROUND;
`else
            r_state <= S_DONE;
`endif
          end
        end
`ifdef SQRT_ROUND_EN
        S_ROUND: r_state <= S_DONE;
`endif
        S_DONE: begin
          if (rsp_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // The root register is frozen outside CALC/ROUND, so DONE holds data stable.
  assign rsp_valid = (r_state == S_DONE);
  assign rsp_id    = r_tag;
  assign rsp_data  = rsp_valid ? RSP_W'(w_root) : '0;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_sqrt_scheduler.sv
// Randomized self-checking bench for sqrt_scheduler against a behavioural model.
// Honours SQRT_ROUND_EN the same way as the design.
module tb_sqrt_scheduler;

`ifdef SQRT_ROUND_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        rsp_ready;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_txn    = 0;
  int m_rr     = 0;

  always #5 clk = ~clk;

  sqrt_scheduler #(.N_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference result: sqrt(op)*16, floored or rounded half up, saturated to 8 bits.
  function automatic int exp_res(input int op);
`ifdef SQRT_ROUND_EN
    real r;
    int  v;
    r = $sqrt(real'(op)) * 16.0;
    v = int'($floor(r + 0.5));
    if (v > 255) v = 255;
    return v;
`else
    int v;
    v = 0;
    while ((v + 1) * (v + 1) <= op * 256) v++;
    return v;
`endif
  endfunction

  function automatic int model_grant(input logic [3:0] valids);
    for (int j = 0; j < 4; j++) begin
      if (valids[(m_rr + j) % 4]) return (m_rr + j) % 4;
    end
    return 0;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the handshake.
  task automatic run_one(input logic [3:0] valids, input logic [31:0] data,
                         input int hold, input bit keep);
    int         g;
    int         cnt;
    int         exp;
    logic [7:0] op;
    bit         bad;
    req_valid = valids;
    req_data  = data;
    #1;
    g   = model_grant(valids);
    op  = data[g*8 +: 8];
    exp = exp_res(int'(op));
    chk("grant", 32'(req_ready), 32'(1) << g);
    chk("busy_idle", 32'(busy), 0);
    @(posedge clk);
    m_rr = (g + 1) % 4;
    @(negedge clk);
    if (!keep) req_valid = '0;
    cnt = 1;
    bad = 1'b0;
    while (!rsp_valid && cnt < 40) begin
      if (req_ready != '0 || !busy) bad = 1'b1;
      @(negedge clk);
      cnt++;
    end
    chk("latency", cnt, LAT);
    chk("calc_ready_busy", 32'(bad), 0);
    chk("rsp_id", 32'(rsp_id), g);
    chk("rsp_data", 32'(rsp_data), exp);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 1);
      chk("hold_data", 32'(rsp_data), exp);
      chk("hold_id", 32'(rsp_id), g);
      chk("hold_ready", 32'(req_ready), 0);
      chk("hold_busy", 32'(busy), 1);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("post_valid", 32'(rsp_valid), 0);
    chk("post_busy", 32'(busy), 0);
    $display("txn %0d id=%0d op=%0d rsp=%04h exp=%04h lat=%0d", n_txn, g, op, rsp_data, exp, cnt);
    n_txn++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  g;
    bit  bad;
    logic [7:0] op;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_id", 32'(rsp_id), 0);
    chk("rst_data", 32'(rsp_data), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    @(negedge clk);

    // All four requesters held: expect grant order 0,1,2,3,0.
    for (int t = 0; t < 5; t++) begin
      run_one(4'hF, {8'd255, 8'd3, 8'd2, 8'd16}, 0, 1'b1);
    end
    req_valid = '0;

    // Boundary and rounding operands, one requester at a time.
    begin
      logic [7:0] ops [5];
      logic [3:0] msk [5];
      ops = '{8'd0, 8'd255, 8'd2, 8'd3, 8'd16};
      msk = '{4'b0100, 4'b1000, 4'b0010, 4'b0001, 4'b0001};
      for (int t = 0; t < 5; t++) begin
        op = ops[t];
        run_one(msk[t], {4{op}}, 0, 1'b0);
      end
    end

    // Consumer back-pressure for 20 cycles.
    run_one(4'b0100, {8'd9, 8'd200, 8'd7, 8'd1}, 20, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_one(4'($urandom_range(1, 15)), $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Reset during the 4th CALC cycle aborts the computation and clears rr_ptr.
    req_valid = 4'b0010;
    req_data  = $urandom;
    #1;
    g = model_grant(4'b0010);
    chk("abort_grant", 32'(req_ready), 32'(1) << g);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 0);
    chk("abort_valid", 32'(rsp_valid), 0);
    chk("abort_id", 32'(rsp_id), 0);
    chk("abort_data", 32'(rsp_data), 0);
    chk("abort_busy", 32'(busy), 0);
    rst  = 1'b0;
    m_rr = 0;
    bad  = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (rsp_valid || busy) bad = 1'b1;
    end
    chk("abort_no_rsp", 32'(bad), 0);
    run_one(4'hF, {8'd100, 8'd50, 8'd25, 8'd4}, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
